// File: rtl/max7219_sequencer.sv
// max7219_sequencer: word source for the MAX7219 SPI serializer (power-up init, then digit refresh).
// Optional feature macro: MAX7219_REINIT_EN (periodic re-init every REINIT_PASSES refresh passes).
module max7219_sequencer #(
    parameter logic [3:0] INTENSITY     = 4'h8,
    parameter int         REINIT_PASSES = 64
) (
    input  logic       sck,
    input  logic       rst_n,
    input  logic       finish,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    output logic [7:0] address,
    output logic [7:0] data,
    output logic       init_done
);

    typedef enum logic {
        ST_INIT    = 1'b0,
        ST_REFRESH = 1'b1
    } state_t;

    state_t     state_q;
    logic [2:0] idx_q;
    logic [7:0] address_q;
    logic [7:0] data_q;
    logic       init_done_q;
    logic [7:0] fb_q [8];

`ifdef MAX7219_REINIT_EN
    logic [7:0] pass_q;
    localparam logic [7:0] PASS_LAST = 8'(REINIT_PASSES - 1);
`endif

    if (REINIT_PASSES < 1 || REINIT_PASSES > 255) begin : g_bad_passes
        $error("REINIT_PASSES must be in 1..255");
    end

    function automatic logic [15:0] init_word(input logic [2:0] i);
        case (i)
            3'd0:    init_word = 16'h0C01;
            3'd1:    init_word = 16'h0900;
            3'd2:    init_word = 16'h0B07;
            3'd3:    init_word = {8'h0A, 4'h0, INTENSITY};
            default: init_word = 16'h0F00;
        endcase
    endfunction

    // Frame buffer; the sequencer reads the pre-write value on a coincident edge.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 8; r++) begin
                fb_q[r] <= 8'h00;
            end
        end else if (wr_en) begin
            fb_q[wr_row] <= wr_data;
        end
    end

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            idx_q       <= 3'd0;
            address_q   <= 8'h0C;
            data_q      <= 8'h01;
            init_done_q <= 1'b0;
`ifdef MAX7219_REINIT_EN
            pass_q      <= 8'd0;
`endif
        end else if (finish) begin
            case (state_q)
                ST_INIT: begin
                    if (idx_q == 3'd4) begin
                        state_q     <= ST_REFRESH;
                        idx_q       <= 3'd0;
                        address_q   <= 8'h01;
                        data_q      <= fb_q[0];
                        init_done_q <= 1'b1;
                    end else begin
                        idx_q                 <= idx_q + 3'd1;
                        {address_q, data_q}   <= init_word(idx_q + 3'd1);
                    end
                end
                default: begin
                    if (idx_q == 3'd7) begin
`ifdef MAX7219_REINIT_EN
                        if (pass_q == PASS_LAST) begin
                            state_q     <= ST_INIT;
                            idx_q       <= 3'd0;
                            address_q   <= 8'h0C;
                            data_q      <= 8'h01;
                            init_done_q <= 1'b0;
                            pass_q      <= 8'd0;
                        end else begin
                            pass_q    <= pass_q + 8'd1;
                            idx_q     <= 3'd0;
                            address_q <= 8'h01;
                            data_q    <= fb_q[0];
                        end
`else
                        idx_q     <= 3'd0;
                        address_q <= 8'h01;
                        data_q    <= fb_q[0];
`endif
                    end else begin
                        idx_q     <= idx_q + 3'd1;
                        address_q <= {5'd0, idx_q} + 8'd2;
                        data_q    <= fb_q[idx_q + 3'd1];
                    end
                end
            endcase
        end
    end

    assign address   = address_q;
    assign data      = data_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_max7219_sequencer.sv
// Scoreboard bench for max7219_sequencer: a driver models the serializer and frame writes and queues
// expected words; a monitor pops one per finish edge and checks the word is held between edges.
module tb_max7219_sequencer;

    localparam int         P   = 2;
    localparam logic [3:0] INT = 4'h8;

    logic       sck     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       finish  = 1'b0;
    logic       wr_en   = 1'b0;
    logic [2:0] wr_row  = 3'd0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] address;
    logic [7:0] data;
    logic       init_done;

    int checks   = 0;
    int failures = 0;

    always #5 sck = ~sck;

    max7219_sequencer #(
        .INTENSITY    (INT),
        .REINIT_PASSES(P)
    ) dut (
        .sck      (sck),
        .rst_n    (rst_n),
        .finish   (finish),
        .wr_en    (wr_en),
        .wr_row   (wr_row),
        .wr_data  (wr_data),
        .address  (address),
        .data     (data),
        .init_done(init_done)
    );

    logic [16:0] exp_q[$];
    logic [16:0] cur_exp;
    logic [7:0]  fb_m [8];
    logic [7:0]  pat  [8] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};
    int          k;
    int          ph;
    int          init_wr;
    bit          directed;

    // Position of word n within the repeating stream (init words, then refresh passes).
    function automatic int word_pos(input int n);
`ifdef MAX7219_REINIT_EN
        return n % (5 + 8 * P);
`else
        return n;
`endif
    endfunction

    function automatic int word_row(input int n);
        int p;
        p = word_pos(n);
        return (p < 5) ? -1 : (p - 5) % 8;
    endfunction

    function automatic logic [16:0] exp_word(input int n);
        int p;
        int r;
        p = word_pos(n);
        if (p < 5) begin
            case (p)
                0:       return {1'b0, 16'h0C01};
                1:       return {1'b0, 16'h0900};
                2:       return {1'b0, 16'h0B07};
                3:       return {1'b0, 8'h0A, 4'h0, INT};
                default: return {1'b0, 16'h0F00};
            endcase
        end
        r = (p - 5) % 8;
        return {1'b1, 8'(r + 1), fb_m[r]};
    endfunction

    task automatic step(input bit rnd);
        bit         fin;
        bit         we;
        logic [2:0] row;
        logic [7:0] d;
        @(negedge sck);
        ph++;
        fin = (ph == 18);
        if (fin) ph = 0;
        we  = 1'b0;
        row = 3'($urandom_range(7));
        d   = 8'($urandom);
        if (init_wr < 8) begin
            we = 1'b1; row = 3'(init_wr); d = pat[init_wr]; init_wr++;
        end else if (directed && fin && word_row(k + 1) == 2) begin
            we = 1'b1; row = 3'd2; d = 8'hFF; directed = 1'b0;
        end else if (rnd && $urandom_range(7) == 0) begin
            we = 1'b1;
        end
        finish  = fin;
        wr_en   = we;
        wr_row  = row;
        wr_data = d;
        // The word loaded on a finish edge uses the buffer as it was before that edge's write.
        if (fin) begin
            k++;
            exp_q.push_back(exp_word(k));
        end
        if (we) fb_m[row] = d;
    endtask

    task automatic do_reset();
        @(negedge sck);
        #2;
        rst_n  = 1'b0;
        finish = 1'b0;
        wr_en  = 1'b0;
        #1;
        checks++;
        if ({init_done, address, data} !== {1'b0, 16'h0C01}) begin
            failures++;
            $display("FAIL reset: got done=%b word=%h%h, expected done=0 word=0c01", init_done, address, data);
        end
        for (int i = 0; i < 8; i++) fb_m[i] = 8'h00;
        k = 0;
        ph = 1;
        exp_q.delete();
        cur_exp = {1'b0, 16'h0C01};
        repeat (3) @(negedge sck);
        rst_n = 1'b1;
    endtask

    // Monitor
    initial begin
        bit          fs;
        bit          rs;
        logic [16:0] got;
        forever begin
            @(posedge sck);
            fs = finish;
            rs = rst_n;
            #1;
            if (rs && rst_n) begin
                got = {init_done, address, data};
                if (fs) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL word: finish edge with no expected word queued, got %h", got);
                    end else begin
                        cur_exp = exp_q.pop_front();
                        if (got !== cur_exp) begin
                            failures++;
                            $display("FAIL word: t=%0t got done=%b word=%h, expected done=%b word=%h",
                                     $time, got[16], got[15:0], cur_exp[16], cur_exp[15:0]);
                        end
                    end
                end else begin
                    checks++;
                    if (got !== cur_exp) begin
                        failures++;
                        $display("FAIL hold: t=%0t got done=%b word=%h, expected done=%b word=%h",
                                 $time, got[16], got[15:0], cur_exp[16], cur_exp[15:0]);
                    end
                end
            end
        end
    end

    // Driver
    initial begin
        int guard;
        init_wr  = 0;
        directed = 1'b0;
        do_reset();
        repeat ((5 + 8 * 2) * 18) step(1'b0);

        directed = 1'b1;
        repeat (2 * 8 * 18) step(1'b0);
        checks++;
        if (directed) begin
            failures++;
            $display("FAIL coincident_write: row 2 finish edge never reached, expected one");
        end

        repeat (4 * 8 * 18) step(1'b1);

        guard = 0;
        while (!(word_row(k) == 4 && ph == 9) && guard < 2000) begin
            step(1'b1);
            guard++;
        end
        checks++;
        if (guard >= 2000) begin
            failures++;
            $display("FAIL seek_digit5: waited %0d cycles, expected under 2000", guard);
        end
        do_reset();
        repeat ((5 + 8 + 2) * 18) step(1'b0);

        repeat (300 * 8 * 18) step(1'b1);

        repeat (2) step(1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected words left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
